// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller: state enum,
// one-hot lamp codes and counter widths.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR_NS = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR_EW = 3'd5
    } state_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam int unsigned CNT_W = 6;
    // One bit wider than the counter so a duration of 64 is representable.
    localparam int unsigned DUR_W = CNT_W + 1;

endpackage

// File: rtl/traffic_phase_timer.sv
// Phase timer: counts cycles in the current phase and flags the last cycle
// (count == duration-1), restarting from 0 on that edge or on reset.
module traffic_phase_timer
    import traffic_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DUR_W-1:0] i_dur,
    output logic [CNT_W-1:0] o_count,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    assign o_done  = ({1'b0, r_count} == (i_dur - DUR_W'(1)));
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (o_done) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic.sv
// Fixed-time two-road traffic-light controller (Moore FSM + phase timer).
// Define TRAFFIC_ALLRED_EN to insert all-red clearance phases after each yellow.
module traffic
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_CYCLES  = 16,
    parameter int unsigned YELLOW_CYCLES = 4,
    parameter int unsigned ALLRED_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] count,
    output logic [2:0]       light_ns,
    output logic [2:0]       light_ew
);

    if (GREEN_CYCLES < 1 || GREEN_CYCLES > 64) begin : g_bad_green
        $error("traffic: GREEN_CYCLES must be in 1..64");
    end
    if (YELLOW_CYCLES < 1 || YELLOW_CYCLES > 64) begin : g_bad_yellow
        $error("traffic: YELLOW_CYCLES must be in 1..64");
    end
    if (ALLRED_CYCLES < 1 || ALLRED_CYCLES > 64) begin : g_bad_allred
        $error("traffic: ALLRED_CYCLES must be in 1..64");
    end

    localparam logic [DUR_W-1:0] LP_G = DUR_W'(GREEN_CYCLES);
    localparam logic [DUR_W-1:0] LP_Y = DUR_W'(YELLOW_CYCLES);
    localparam logic [DUR_W-1:0] LP_A = DUR_W'(ALLRED_CYCLES);

    state_t           r_state;
    state_t           w_next;
    logic [DUR_W-1:0] w_dur;
    logic             w_done;

    traffic_phase_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_dur   (w_dur),
        .o_count (count),
        .o_done  (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= NS_G;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_dur    = LP_G;
        light_ns = RED;
        light_ew = RED;
        case (r_state)
            NS_G: begin
                w_dur    = LP_G;
                light_ns = GREEN;
                if (w_done) w_next = NS_Y;
            end
            NS_Y: begin
                w_dur    = LP_Y;
                light_ns = YELLOW;
`ifdef TRAFFIC_ALLRED_EN
                if (w_done) w_next = AR_NS;
`else
                if (w_done) w_next = EW_G;
`endif
            end
            AR_NS: begin
                w_dur = LP_A;
                if (w_done) w_next = EW_G;
            end
            EW_G: begin
                w_dur    = LP_G;
                light_ew = GREEN;
                if (w_done) w_next = EW_Y;
            end
            EW_Y: begin
                w_dur    = LP_Y;
                light_ew = YELLOW;
`ifdef TRAFFIC_ALLRED_EN
                if (w_done) w_next = AR_EW;
`else
                if (w_done) w_next = NS_G;
`endif
            end
            AR_EW: begin
                w_dur = LP_A;
                if (w_done) w_next = NS_G;
            end
            default: begin
                w_next = NS_G;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic.sv
// Self-checking bench for traffic: directed steps plus randomized resets,
// checked against a period/phase-table reference model.
module tb_traffic;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    localparam int unsigned G2 = 1;
    localparam int unsigned Y2 = 64;
    localparam int unsigned A2 = 1;

`ifdef TRAFFIC_ALLRED_EN
    localparam int unsigned AR_DEF = 2;
`else
    localparam int unsigned AR_DEF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] count, count2;
    logic [2:0] light_ns, light_ew, light_ns2, light_ew2;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned t     = 0;

    always #5 clk = ~clk;

    traffic #(.GREEN_CYCLES(16), .YELLOW_CYCLES(4), .ALLRED_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .count(count), .light_ns(light_ns), .light_ew(light_ew)
    );

    traffic #(.GREEN_CYCLES(G2), .YELLOW_CYCLES(Y2), .ALLRED_CYCLES(A2)) u_dut2 (
        .clk(clk), .rst(rst), .count(count2), .light_ns(light_ns2), .light_ew(light_ew2)
    );

    // Expected outputs t non-reset edges after the last reset edge.
    function automatic void model(input int unsigned tt, input int unsigned g,
                                  input int unsigned y, input int unsigned a,
                                  output logic [5:0] c, output logic [2:0] ns,
                                  output logic [2:0] ew);
        int unsigned dur[6];
        logic [2:0]  lns[6];
        logic [2:0]  lew[6];
        int unsigned n, period, p;
`ifdef TRAFFIC_ALLRED_EN
        dur = '{g, y, a, g, y, a};
        lns = '{G, Y, R, R, R, R};
        lew = '{R, R, R, G, Y, R};
        n   = 6;
`else
        dur = '{g, y, g, y, 0, 0};
        lns = '{G, Y, R, R, R, R};
        lew = '{R, R, G, Y, R, R};
        n   = 4;
`endif
        period = 0;
        for (int unsigned i = 0; i < n; i++) period += dur[i];
        p  = tt % period;
        c  = 'x;
        ns = 'x;
        ew = 'x;
        for (int unsigned i = 0; i < n; i++) begin
            if (p < dur[i]) begin
                c  = 6'(p);
                ns = lns[i];
                ew = lew[i];
                break;
            end
            p -= dur[i];
        end
    endfunction

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [5:0] ec;
        logic [2:0] ens, eew;
        model(t, 16, 4, 2, ec, ens, eew);
        chk("count", count, ec);
        chk("light_ns", {3'b0, light_ns}, {3'b0, ens});
        chk("light_ew", {3'b0, light_ew}, {3'b0, eew});
        chk("safety", {5'b0, (light_ns == R) || (light_ew == R)}, 6'd1);
        chk("onehot", {5'b0, $onehot(light_ns) && $onehot(light_ew)}, 6'd1);
        model(t, G2, Y2, A2, ec, ens, eew);
        chk("count2", count2, ec);
        chk("light_ns2", {3'b0, light_ns2}, {3'b0, ens});
        chk("light_ew2", {3'b0, light_ew2}, {3'b0, eew});
        chk("safety2", {5'b0, (light_ns2 == R) || (light_ew2 == R)}, 6'd1);
    endtask

    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        #1;
        if (r) t = 0;
        else   t++;
        check_all();
    endtask

    initial begin
        // Reset held for two edges, then the first cycle after release.
        step(1'b1);
        step(1'b1);
        chk("rst_count", count, 6'd0);
        chk("rst_ns", {3'b0, light_ns}, {3'b0, G});
        chk("rst_ew", {3'b0, light_ew}, {3'b0, R});
        rst = 1'b0;
        #4;
        chk("post_rst_ns", {3'b0, light_ns}, {3'b0, G});
        chk("post_rst_cnt", count, 6'd0);

        // Green lasts 16 edges, then yellow appears with count 0.
        for (int i = 0; i < 15; i++) step(1'b0);
        chk("green_last_cnt", count, 6'd15);
        step(1'b0);
        chk("ns_yellow", {3'b0, light_ns}, {3'b0, Y});
        chk("ns_yellow_cnt", count, 6'd0);

        // Complete one full period: back to NS_G with count 0.
        while (t < 2 * (16 + 4 + AR_DEF)) step(1'b0);
        chk("period_ns", {3'b0, light_ns}, {3'b0, G});
        chk("period_cnt", count, 6'd0);

        // Mid-operation reset during EW_G at count 7.
        step(1'b1);
        while (t < 16 + 4 + AR_DEF + 7) step(1'b0);
        chk("ewg_cnt7", count, 6'd7);
        chk("ewg_lamp", {3'b0, light_ew}, {3'b0, G});
        step(1'b1);
        chk("mid_rst_ns", {3'b0, light_ns}, {3'b0, G});
        chk("mid_rst_cnt", count, 6'd0);

        // Long uninterrupted run exercises the 64-cycle yellow of the second instance.
        for (int i = 0; i < 140; i++) step(1'b0);

        // Randomized sporadic resets.
        for (int i = 0; i < 400; i++) step($urandom_range(0, 39) == 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0d", t);
        $fatal(1, "timeout");
    end

endmodule
